// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and constants for the program counter unit
package pc_pkg;

    localparam int PC_W = 8;

    localparam logic [PC_W-1:0] VEC_RESET = 8'h00;
    localparam logic [PC_W-1:0] VEC_INT   = 8'h01;

    // One-hot encoding so any corrupted pattern is caught by the default arm
    typedef enum logic [2:0] {
        S_VEC_RST = 3'b001,
        S_RUN     = 3'b010,
        S_VEC_INT = 3'b100
    } pc_state_t;

endpackage

// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - fetch-control bus between pipeline/memory and pc_unit
interface pc_unit_if;
    import pc_pkg::*;

    logic            b_take;
    logic [PC_W-1:0] b_target;
    logic            stall;
    logic            int_req;
    logic [PC_W-1:0] mem_data;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_plus1;
    logic            vec_rd;
    logic [PC_W-1:0] vec_addr;
    logic            flush;
    logic            int_ack;
    logic [PC_W-1:0] ret_pc;

    modport master (
        output b_take, b_target, stall, int_req, mem_data,
        input  pc, pc_plus1, vec_rd, vec_addr, flush, int_ack, ret_pc
    );

    modport slave (
        input  b_take, b_target, stall, int_req, mem_data,
        output pc, pc_plus1, vec_rd, vec_addr, flush, int_ack, ret_pc
    );

endinterface

// File: rtl/pc_vec_fsm.sv
// rtl/pc_vec_fsm.sv - vector-load sequencer: state register and fetch-control decode
module pc_vec_fsm
    import pc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            b_take,
    input  logic            int_accept,
    output logic            in_run,
    output logic            vec_rd,
    output logic [PC_W-1:0] vec_addr,
    output logic            flush,
    output logic            int_ack
);

    pc_state_t state_q;
    pc_state_t state_d;

    // State register; reset always restarts the reset-vector fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_VEC_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-state decode; illegal encodings behave like reset
    always_comb begin
        state_d  = state_q;
        in_run   = 1'b0;
        vec_rd   = 1'b0;
        vec_addr = VEC_RESET;
        flush    = 1'b0;
        int_ack  = 1'b0;
        case (state_q)
            S_VEC_RST: begin
                vec_rd  = 1'b1;
                flush   = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
                in_run = 1'b1;
                flush  = b_take;
                if (int_accept) begin
                    state_d = S_VEC_INT;
                end
            end
            S_VEC_INT: begin
                vec_rd   = 1'b1;
                vec_addr = VEC_INT;
                flush    = 1'b1;
                int_ack  = 1'b1;
                state_d  = S_RUN;
            end
            default: begin
                vec_rd  = 1'b1;
                flush   = 1'b1;
                state_d = S_VEC_RST;
            end
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with branch, stall, reset vector and optional interrupt vector (PC_UNIT_INT_EN)
module pc_unit
    import pc_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    pc_unit_if.slave bus
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] pc_inc;
    logic            in_run;
    logic            vec_rd;
    logic [PC_W-1:0] vec_addr;
    logic            flush;
    logic            int_ack;
    logic            int_accept;

    assign pc_inc = pc_q + 8'd1;

    pc_vec_fsm u_fsm (
        .clk        (clk),
        .rst        (rst),
        .b_take     (bus.b_take),
        .int_accept (int_accept),
        .in_run     (in_run),
        .vec_rd     (vec_rd),
        .vec_addr   (vec_addr),
        .flush      (flush),
        .int_ack    (int_ack)
    );

`ifdef PC_UNIT_INT_EN
    logic            int_pend_q;
    logic [PC_W-1:0] ret_pc_q;

    // A pending interrupt is taken only on a cycle that would otherwise increment
    assign int_accept = in_run & int_pend_q & ~bus.b_take & ~bus.stall;

    // Latch the request level while running; only acceptance clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_pend_q <= 1'b0;
        end else if (int_accept) begin
            int_pend_q <= 1'b0;
        end else if (in_run && bus.int_req) begin
            int_pend_q <= 1'b1;
        end
    end

    // Return address is the instruction after the one interrupted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ret_pc_q <= VEC_RESET;
        end else if (int_accept) begin
            ret_pc_q <= pc_inc;
        end
    end

    assign bus.ret_pc  = ret_pc_q;
    assign bus.int_ack = int_ack;
`else
    logic unused_int_req;

    assign unused_int_req = bus.int_req | int_ack;
    assign int_accept     = 1'b0;
    assign bus.ret_pc     = VEC_RESET;
    assign bus.int_ack    = 1'b0;
`endif

    // Next fetch address: vector load, then branch > accept-hold > stall-hold > increment
    always_comb begin
        pc_d = pc_q;
        if (vec_rd) begin
            pc_d = bus.mem_data;
        end else if (bus.b_take) begin
            pc_d = bus.b_target;
        end else if (int_accept || bus.stall) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_inc;
        end
    end

    // Fetch address register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= VEC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus1 = pc_inc;
    assign bus.vec_rd   = vec_rd;
    assign bus.vec_addr = vec_addr;
    assign bus.flush    = flush;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed self-checking bench for pc_unit
module tb_pc_unit;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;

    pc_unit_if bus ();

    pc_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: got %02h want %02h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst          = 1'b1;
        bus.b_take   = 1'b0;
        bus.b_target = 8'h00;
        bus.stall    = 1'b0;
        bus.int_req  = 1'b0;
        bus.mem_data = 8'h40;

        // Reset state
        cyc();
        chk("rst_pc",       bus.pc,       8'h00);
        chk("rst_ret_pc",   bus.ret_pc,   8'h00);
        chk("rst_vec_rd",   {7'd0, bus.vec_rd},  8'h01);
        chk("rst_vec_addr", bus.vec_addr, 8'h00);
        chk("rst_flush",    {7'd0, bus.flush},   8'h01);
        chk("rst_int_ack",  {7'd0, bus.int_ack}, 8'h00);

        // Release: one vector-load cycle, then 0x40, 0x41
        rst = 1'b0;
        #1;
        chk("vld_vec_rd", {7'd0, bus.vec_rd}, 8'h01);
        chk("vld_flush",  {7'd0, bus.flush},  8'h01);
        cyc();
        chk("vld_pc",       bus.pc,       8'h40);
        chk("run_vec_rd",   {7'd0, bus.vec_rd}, 8'h00);
        chk("run_flush",    {7'd0, bus.flush},  8'h00);
        chk("run_pc_plus1", bus.pc_plus1, 8'h41);
        cyc();
        chk("inc_pc", bus.pc, 8'h41);

        // Branch to 0x10
        bus.b_take = 1'b1; bus.b_target = 8'h10;
        #1;
        chk("br1_flush", {7'd0, bus.flush}, 8'h01);
        cyc();
        bus.b_take = 1'b0;
        #1;
        chk("br1_pc",     bus.pc, 8'h10);
        chk("br1_noflush", {7'd0, bus.flush}, 8'h00);

        // Branch wins over stall
        bus.b_take = 1'b1; bus.stall = 1'b1; bus.b_target = 8'h80;
        #1;
        chk("brst_flush", {7'd0, bus.flush}, 8'h01);
        cyc();
        bus.b_take = 1'b0;
        #1;
        chk("brst_pc",    bus.pc, 8'h80);
        chk("stall_flush", {7'd0, bus.flush}, 8'h00);
        cyc();
        chk("stall_hold", bus.pc, 8'h80);
        bus.stall = 1'b0;

        // Wrap 0xFF -> 0x00
        bus.b_take = 1'b1; bus.b_target = 8'hFF;
        cyc();
        bus.b_take = 1'b0;
        #1;
        chk("wrap_pc",       bus.pc,       8'hFF);
        chk("wrap_pc_plus1", bus.pc_plus1, 8'h00);
        cyc();
        chk("wrap_next", bus.pc, 8'h00);

`ifdef PC_UNIT_INT_EN
        // Interrupt held pending under stall
        bus.b_take = 1'b1; bus.b_target = 8'h20;
        cyc();
        bus.b_take = 1'b0; bus.stall = 1'b1; bus.int_req = 1'b1;
        #1;
        chk("int_pc_a", bus.pc, 8'h20);
        cyc();
        bus.int_req = 1'b0;
        #1;
        chk("int_pc_b",  bus.pc, 8'h20);
        chk("int_ack_b", {7'd0, bus.int_ack}, 8'h00);
        cyc();
        bus.stall = 1'b0;
        #1;
        chk("int_pc_c",  bus.pc, 8'h20);
        chk("int_ack_c", {7'd0, bus.int_ack}, 8'h00);
        cyc();
        bus.mem_data = 8'hC0;
        chk("iv_int_ack",  {7'd0, bus.int_ack}, 8'h01);
        chk("iv_vec_rd",   {7'd0, bus.vec_rd},  8'h01);
        chk("iv_vec_addr", bus.vec_addr, 8'h01);
        chk("iv_flush",    {7'd0, bus.flush},   8'h01);
        chk("iv_ret_pc",   bus.ret_pc,   8'h21);
        // Requests, branches during the vector cycle are ignored
        bus.int_req = 1'b1; bus.b_take = 1'b1; bus.b_target = 8'h33;
        cyc();
        bus.int_req = 1'b0; bus.b_take = 1'b0;
        #1;
        chk("iv_load_pc", bus.pc, 8'hC0);
        chk("iv_ack_off", {7'd0, bus.int_ack}, 8'h00);
        cyc();
        chk("iv_ign_pc", bus.pc, 8'hC1);
        cyc();
        chk("iv_ign_pc2", bus.pc, 8'hC2);
        chk("iv_ign_ack", {7'd0, bus.int_ack}, 8'h00);

        // Interrupt and branch in the same cycle
        bus.b_take = 1'b1; bus.b_target = 8'h50; bus.int_req = 1'b1;
        cyc();
        bus.b_take = 1'b0; bus.int_req = 1'b0;
        #1;
        chk("ib_pc",  bus.pc, 8'h50);
        chk("ib_ack", {7'd0, bus.int_ack}, 8'h00);
        cyc();
        bus.mem_data = 8'h60;
        chk("ib_int_ack", {7'd0, bus.int_ack}, 8'h01);
        chk("ib_ret_pc",  bus.ret_pc, 8'h51);
        cyc();
        chk("ib_vec_pc", bus.pc, 8'h60);

        // Reset during the interrupt vector cycle
        bus.int_req = 1'b1;
        cyc();
        bus.int_req = 1'b0;
        cyc();
        chk("ri_int_ack", {7'd0, bus.int_ack}, 8'h01);
        rst = 1'b1;
        bus.mem_data = 8'h40;
        #1;
        chk("ri_ack_off",  {7'd0, bus.int_ack}, 8'h00);
        chk("ri_vec_addr", bus.vec_addr, 8'h00);
        chk("ri_vec_rd",   {7'd0, bus.vec_rd}, 8'h01);
        chk("ri_pc",       bus.pc,     8'h00);
        chk("ri_ret_pc",   bus.ret_pc, 8'h00);
        cyc();
        rst = 1'b0;
        cyc();
        chk("ri_reload_pc", bus.pc, 8'h40);
        chk("ri_pend_ack",  {7'd0, bus.int_ack}, 8'h00);
        cyc();
        chk("ri_pend_clr", bus.pc, 8'h41);
`else
        // Interrupt path absent: requests have no effect
        bus.int_req = 1'b1;
        cyc();
        chk("noint_pc",  bus.pc, 8'h01);
        chk("noint_ack", {7'd0, bus.int_ack}, 8'h00);
        cyc();
        chk("noint_pc2", bus.pc, 8'h02);
        chk("noint_ret", bus.ret_pc, 8'h00);
        cyc();
        chk("noint_vec", {7'd0, bus.vec_rd}, 8'h00);
        bus.int_req = 1'b0;
        rst = 1'b1;
        #1;
        chk("noint_rst_pc", bus.pc, 8'h00);
        cyc();
        rst = 1'b0;
        cyc();
        chk("noint_reload", bus.pc, 8'h40);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Ports: clk  in  1  system clock, all state updates on rising edge.
REQ-002 Ports: rst  in  1  asynchronous, active-high reset.
REQ-003 Ports: b_take  in  1  branch-taken decision from branch unit.
REQ-004 Ports: b_target  in  8  branch/jump/return target address.
REQ-005 Ports: stall  in  1  hazard stall; hold PC.
REQ-006 Ports: int_req  in  1  external interrupt request, level.
REQ-007 Ports: mem_data  in  8  combinational read data of vector word (same cycle as vec_addr).
REQ-008 Ports: pc  out  8  current fetch address, registered.
REQ-009 Ports: pc_plus1  out  8  pc+1 mod 256, combinational.
REQ-010 Ports: vec_rd  out  1  vector read strobe.
REQ-011 Ports: vec_addr  out  8  vector address (8'h00 reset, 8'h01 interrupt).
REQ-012 Ports: flush  out  1  kill IF/ID contents this cycle.
REQ-013 Ports: int_ack  out  1  one-cycle interrupt acceptance pulse.
REQ-014 Ports: ret_pc  out  8  saved return address for interrupt push, registered.

Function
REQ-015 FSM states: S_VEC_RST, S_RUN, S_VEC_INT; one-hot-safe, illegal state -> S_VEC_RST.
REQ-016 S_VEC_RST: vec_rd=1, vec_addr=8'h00, flush=1; on next edge pc<=mem_data, state->S_RUN (1-cycle vector load).
REQ-017 S_RUN priority per edge: b_take > interrupt accept > stall > increment.
REQ-018 S_RUN, b_take=1: pc<=b_target, flush=1 same cycle (combinational), regardless of stall.
REQ-019 S_RUN, b_take=0, stall=1: pc holds, flush=0.
REQ-020 S_RUN, b_take=0, stall=0, no accept: pc<=pc+1, wrap 8'hFF->8'h00.
REQ-021 int_pend register set when int_req=1 in S_RUN; cleared on acceptance only.
REQ-022 Accept when state=S_RUN, int_pend=1, b_take=0, stall=0: ret_pc<=pc+1, state->S_VEC_INT.
REQ-023 S_VEC_INT: vec_rd=1, vec_addr=8'h01, flush=1, int_ack=1; next edge pc<=mem_data, state->S_RUN.
REQ-024 int_req ignored (not latched) during S_VEC_RST and S_VEC_INT; no nesting.
REQ-025 b_take or stall during S_VEC_RST/S_VEC_INT ignored.
REQ-026 vec_rd=0, vec_addr=8'h00, int_ack=0 in S_RUN.

Reset
REQ-027 rst=1 asynchronously: state=S_VEC_RST, pc=8'h00, ret_pc=8'h00, int_pend=0; outputs follow S_VEC_RST decode (vec_rd=1, flush=1, int_ack=0).
REQ-028 rst asserted mid-vector-load or mid-branch aborts it; vector fetch restarts after release.

Configuration
REQ-029 Macro PC_UNIT_INT_EN: defined -> interrupt path per REQ-021..024; undefined -> S_VEC_INT, int_pend, ret_pc logic absent, int_ack=0, ret_pc=8'h00, int_req unused.

Structure
REQ-030 Shared package pc_pkg: state encodings, VEC_RESET=8'h00, VEC_INT=8'h01, PC_W=8.
REQ-031 One sub-module pc_vec_fsm: state register and vec_rd/vec_addr/flush/int_ack decode; pc datapath in pc_unit.

Verification
REQ-032 Reset, mem_data=8'h40 -> one cycle vec_rd=1 vec_addr=0 flush=1, then pc=8'h40, then 8'h41.
REQ-033 pc=8'h10, b_take=1 stall=1 b_target=8'h80 -> flush=1 that cycle, next pc=8'h80.
REQ-034 pc=8'hFF, no events -> next pc=8'h00, pc_plus1 wraps likewise.
REQ-035 pc=8'h20, int_req pulse with stall=1 two cycles -> held pending; after stall drops ret_pc=8'h21, int_ack=1 with vec_addr=1, mem_data=8'hC0 -> pc=8'hC0.
REQ-036 int_req and b_take same cycle -> branch taken first, interrupt accepted next eligible cycle with ret_pc=b_target+1.
REQ-037 rst asserted during S_VEC_INT -> immediate S_VEC_RST outputs, int_pend=0, int_ack=0.
